ex_mult_seq: RTL and testbench

Multi-cycle shift-add multiply sequencer attached to the execute stage. It accepts a multiply request decoded alongside the ALU controls, iterates one partial product per cycle, and holds the pipeline with a stall while it works. When the product is ready it presents the result for one cycle. It also handles the flush (branch mispredict) and reset abort paths.

---
 rtl/ex_mult_seq_pkg.sv | 15 +
 rtl/ex_mult_seq_mult_shift_add.sv | 59 +++++
 rtl/ex_mult_seq.sv | 188 ++++++++++++++++++
 tb/tb_ex_mult_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mult_seq_pkg.sv
// ex_mult_seq_pkg: shared definitions for the multi-cycle shift-add multiply
// sequencer (state encoding and default operand width).
package ex_mult_seq_pkg;

    // Default operand/result width; the iteration count equals the width.
    localparam int DEFAULT_WIDTH = 16;

    // Sequencer states. Encoding is fixed so traces are easy to read.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage : ex_mult_seq_pkg

// File: rtl/ex_mult_seq_mult_shift_add.sv
// mult_shift_add: accumulator datapath of the shift-add multiplier.
// load clears the 2*WIDTH accumulator; step adds mcand<<count when the
// multiplier bit selected by count is set. product_o is the accumulator value
// including the partial product of the current step, so the sequencer can
// capture the final product in the same cycle as the last step.
module mult_shift_add
    import ex_mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [CW-1:0]      count_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] product_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] addend_s;

    // Partial product for the current multiplier bit (zero when bit is clear).
    always_comb begin
        addend_s = '0;
        if (mplier_i[count_i]) begin
            addend_s = {{WIDTH{1'b0}}, mcand_i} << count_i;
        end else begin
            addend_s = '0;
        end
    end

    // Accumulator next state: clear on load, accumulate on step, else hold.
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = '0;
        end else if (step_i) begin
            acc_d = acc_q + addend_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign product_o = acc_q + addend_s;

endmodule : mult_shift_add

// File: rtl/ex_mult_seq.sv
// ex_mult_seq: multi-cycle shift-add multiply sequencer for the execute stage.
// One partial product per cycle for WIDTH cycles, pipeline stall while busy,
// one-cycle done pulse with the registered product. flush aborts, rst aborts.
// Optional feature: define MULT_HI_EN to produce the upper product half on
// result_hi (signed or unsigned per the latched sign); otherwise result_hi is 0.
module ex_mult_seq
    import ex_mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sign,
    input  logic             flush,
    output logic             stall_ex,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e             state_q;
    state_e             state_d;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   result_q;
    logic               load_s;
    logic               step_s;
    logic               finish_s;
    logic [2*WIDTH-1:0] product_s;

    // Next-state, counter and datapath control for the sequencer.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        load_s   = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else begin
                    step_s = 1'b1;
                    if (count_q == LAST_CNT) begin
                        state_d  = ST_DONE;
                        count_d  = '0;
                        finish_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_DONE: begin
                // start still belongs to the finishing instruction here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State and iteration counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Operand latches, captured when a request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load_s) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
        end else begin
            mcand_q  <= mcand_q;
            mplier_q <= mplier_q;
        end
    end

    mult_shift_add #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_s),
        .step_i    (step_s),
        .count_i   (count_q),
        .mcand_i   (mcand_q),
        .mplier_i  (mplier_q),
        .product_o (product_s)
    );

    // Low product word, captured on the transition into DONE and held after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (finish_s) begin
            result_q <= product_s[WIDTH-1:0];
        end else begin
            result_q <= result_q;
        end
    end

`ifdef MULT_HI_EN
    logic             sign_q;
    logic [WIDTH-1:0] hi_fix_s;
    logic [WIDTH-1:0] result_hi_q;

    // Signedness latch, captured alongside the operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q <= 1'b0;
        end else if (load_s) begin
            sign_q <= sign;
        end else begin
            sign_q <= sign_q;
        end
    end

    // Upper half: unsigned product, minus the two's-complement corrections
    // (b if a is negative, a if b is negative) when operands are signed.
    always_comb begin
        hi_fix_s = product_s[2*WIDTH-1:WIDTH];
        if (sign_q) begin
            hi_fix_s = product_s[2*WIDTH-1:WIDTH]
                     - (mcand_q[WIDTH-1]  ? mplier_q : {WIDTH{1'b0}})
                     - (mplier_q[WIDTH-1] ? mcand_q  : {WIDTH{1'b0}});
        end else begin
            hi_fix_s = product_s[2*WIDTH-1:WIDTH];
        end
    end

    // High product word, captured on the transition into DONE and held after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_hi_q <= '0;
        end else if (finish_s) begin
            result_hi_q <= hi_fix_s;
        end else begin
            result_hi_q <= result_hi_q;
        end
    end

    assign result_hi = result_hi_q;
`else
    // Upper product bits and sign have no consumer in this build.
    logic unused_hi_s;
    assign unused_hi_s = ^{sign, product_s[2*WIDTH-1:WIDTH]};
    assign result_hi   = {WIDTH{1'b0}};
`endif

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    // Combinational so the accepting cycle already holds the pipeline.
    assign stall_ex = !rst && (((state_q == ST_IDLE) && start && !flush)
                               || (state_q == ST_RUN));

endmodule : ex_mult_seq

// File: tb/tb_ex_mult_seq.sv
// tb_ex_mult_seq: self-checking bench for ex_mult_seq (WIDTH=16). Expected
// products come from plain integer multiplication of the operands.
module tb_ex_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        sign;
    logic        flush;
    logic        stall_ex;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] result_hi;

    int          total;
    int          bad;
    logic [15:0] last_lo;
    logic [15:0] last_hi;

    ex_mult_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .sign      (sign),
        .flush     (flush),
        .stall_ex  (stall_ex),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference product for the given operands.
    task automatic ref_mult(input logic [15:0] a, input logic [15:0] b, input logic s,
                            output logic [15:0] lo, output logic [15:0] hi);
        logic [31:0] pu;
        logic signed [31:0] ps;
        pu = {16'h0000, a} * {16'h0000, b};
        ps = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        lo = pu[15:0];
`ifdef MULT_HI_EN
        hi = s ? ps[31:16] : pu[31:16];
`else
        hi = 16'h0000;
        if (s && ps[0]) hi = 16'h0000;
`endif
    endtask

    // Issue one multiply from a negedge, wait for done, check timing and data.
    // keep=1 leaves start high after done (back-to-back case).
    task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input logic s,
                            input bit keep, input string tag);
        int          n;
        bit          stall_ok;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
        ref_mult(a, b, s, exp_lo, exp_hi);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        sign  = s;
        #1;
        check_eq({tag, "_stall_c0"}, {31'd0, stall_ex}, 32'd1);
        n        = 0;
        stall_ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (done !== 1'b1 && (stall_ex !== 1'b1 || busy !== 1'b1)) stall_ok = 1'b0;
        end
        check_eq({tag, "_latency"}, n, 32'd17);
        check_eq({tag, "_stall_run"}, {31'd0, stall_ok}, 32'd1);
        check_eq({tag, "_stall_done"}, {31'd0, stall_ex}, 32'd0);
        check_eq({tag, "_lo"}, {16'd0, result}, {16'd0, exp_lo});
        check_eq({tag, "_hi"}, {16'd0, result_hi}, {16'd0, exp_hi});
        last_lo = exp_lo;
        last_hi = exp_hi;
        if (!keep) begin
            start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_pulse"}, {31'd0, done}, 32'd0);
            check_eq({tag, "_hold"}, {16'd0, result}, {16'd0, exp_lo});
        end
    endtask

    initial begin
        bit seen_done;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = 16'h0000;
        op_b  = 16'h0000;
        sign  = 1'b0;
        flush = 1'b0;
        last_lo = 16'h0000;
        last_hi = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_stall", {31'd0, stall_ex}, 32'd0);
        check_eq("rst_result", {16'd0, result}, 32'd0);
        check_eq("rst_result_hi", {16'd0, result_hi}, 32'd0);

        // Directed cases.
        run_mult(16'h0003, 16'h0005, 1'b0, 1'b0, "basic");
        run_mult(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "ones_u");
        run_mult(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "ones_s");
        run_mult(16'hFFFE, 16'h0003, 1'b1, 1'b0, "mixed");
        run_mult(16'h0000, 16'hABCD, 1'b1, 1'b0, "zero");
        run_mult(16'h8000, 16'h8000, 1'b1, 1'b0, "minneg");

        // Flush in RUN cycle 5: back to IDLE, no done, result untouched.
        start = 1'b1;
        op_a  = 16'h1234;
        op_b  = 16'h00FF;
        sign  = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("flush_idle_stall", {31'd0, stall_ex}, 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) seen_done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("flush_no_done", {31'd0, seen_done}, 32'd0);
        check_eq("flush_result_hold", {16'd0, result}, {16'd0, last_lo});

        // Flush together with start in IDLE: request not accepted.
        start = 1'b1;
        flush = 1'b1;
        #1;
        check_eq("flush_start_stall", {31'd0, stall_ex}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("flush_start_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        flush = 1'b0;

        // Asynchronous reset in cycle 8 of an operation.
        start = 1'b1;
        op_a  = 16'h0101;
        op_b  = 16'h0F0F;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_stall", {31'd0, stall_ex}, 32'd0);
        check_eq("arst_done", {31'd0, done}, 32'd0);
        check_eq("arst_result", {16'd0, result}, 32'd0);
        check_eq("arst_result_hi", {16'd0, result_hi}, 32'd0);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_mult(16'h0002, 16'h0002, 1'b0, 1'b0, "post_rst");

        // Back-to-back: start held through DONE, next pair in the IDLE cycle.
        run_mult(16'h0011, 16'h0002, 1'b0, 1'b1, "b2b_first");
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("b2b_idle_done", {31'd0, done}, 32'd0);
        check_eq("b2b_idle_stall", {31'd0, stall_ex}, 32'd1);
        run_mult(16'h0007, 16'h0009, 1'b0, 1'b0, "b2b_second");

        // Randomized operands and signedness.
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (i % 6 == 0) ra = 16'h8000 | ra;
            if (i % 6 == 1) rb = 16'hFFFF;
            run_mult(ra, rb, rs, 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ex_mult_seq
